// File: rtl/usb_dev_protocol_if.sv
// ============================================================================
// Module      : usb_dev_protocol_if
// Description : Packet, endpoint-buffer and status signals of the device-side
//               USB protocol responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface usb_dev_protocol_if;
    logic [6:0]  dev_addr;
    logic [98:0] pkt_in;
    logic        pkt_in_avail;
    logic        pkt_in_corrupt;
    logic [98:0] pkt_out;
    logic        pkt_out_avail;
    logic        pkt_sent;
    logic [63:0] tx_data;
    logic        tx_data_valid;
    logic        tx_data_taken;
    logic        rx_ready;
    logic [63:0] rx_data;
    logic        rx_data_valid;
    logic        txn_done;
    logic        txn_ok;

    // master: decoder/encoder/buffer side; slave: the protocol responder
    modport master (
        output dev_addr, pkt_in, pkt_in_avail, pkt_in_corrupt, pkt_sent,
               tx_data, tx_data_valid, rx_ready,
        input  pkt_out, pkt_out_avail, tx_data_taken, rx_data, rx_data_valid,
               txn_done, txn_ok
    );

    modport slave (
        input  dev_addr, pkt_in, pkt_in_avail, pkt_in_corrupt, pkt_sent,
               tx_data, tx_data_valid, rx_ready,
        output pkt_out, pkt_out_avail, tx_data_taken, rx_data, rx_data_valid,
               txn_done, txn_ok
    );
endinterface

`default_nettype wire

// File: rtl/usb_dev_protocol.sv
// ============================================================================
// Module      : usb_dev_protocol
// Description : Device-side USB protocol responder answering IN/OUT tokens for
//               one endpoint. Define USB_DEV_TOGGLE_EN for DATA0/DATA1 toggling.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module usb_dev_protocol #(
    parameter logic [7:0] TIMEOUT_LEN = 8'd255,
    parameter logic [3:0] ENDP        = 4'd4
) (
    input  wire logic          clk,
    input  wire logic          rst_b,
    usb_dev_protocol_if.slave  bus
);

    localparam logic [7:0] SYNC      = 8'h01;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_DATA = 3'd1,
        TX_HS   = 3'd2,
        RX_WAIT = 3'd3,
        SEND_HS = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  timer, timer_nxt;
    logic [98:0] pkt_out_q, pkt_out_nxt;
    logic        avail_q, avail_nxt;
    logic        taken_q, taken_nxt;
    logic [63:0] rx_data_q, rx_data_nxt;
    logic        rxv_q, rxv_nxt;
    logic        done_q, done_nxt;
    logic        ok_q, ok_nxt;

    logic [7:0]  in_pid;
    logic [6:0]  in_addr;
    logic [3:0]  in_endp;
    logic [63:0] in_payload;
    logic        pkt_good;
    logic        is_token;
    logic        token_good;
    logic        token_match;
    logic        data_good;
    logic        timeout;
    logic [7:0]  tx_pid;
    logic        seq_ok;

    assign in_pid      = bus.pkt_in[90:83];
    assign in_addr     = bus.pkt_in[82:76];
    assign in_endp     = bus.pkt_in[75:72];
    assign in_payload  = bus.pkt_in[82:19];
    assign pkt_good    = bus.pkt_in_avail & ~bus.pkt_in_corrupt;
    assign is_token    = (in_pid == PID_IN) || (in_pid == PID_OUT);
    assign token_good  = pkt_good & is_token;
    assign token_match = pkt_good & (in_addr == bus.dev_addr) & (in_endp == ENDP);
    assign data_good   = pkt_good & ((in_pid == PID_DATA0) || (in_pid == PID_DATA1));
    assign timeout     = (timer == TIMEOUT_LEN);

`ifdef USB_DEV_TOGGLE_EN
    logic tx_tog, tx_tog_nxt;
    logic rx_tog, rx_tog_nxt;

    assign tx_pid = tx_tog ? PID_DATA1 : PID_DATA0;
    assign seq_ok = (in_pid == (rx_tog ? PID_DATA1 : PID_DATA0));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tx_tog <= 1'b0;
            rx_tog <= 1'b0;
        end else begin
            tx_tog <= tx_tog_nxt;
            rx_tog <= rx_tog_nxt;
        end
    end
`else
    assign tx_pid = PID_DATA0;
    assign seq_ok = 1'b1;
`endif

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        pkt_out_nxt = pkt_out_q;
        avail_nxt   = avail_q;
        rx_data_nxt = rx_data_q;
        taken_nxt   = 1'b0;
        rxv_nxt     = 1'b0;
        done_nxt    = 1'b0;
        ok_nxt      = 1'b0;
`ifdef USB_DEV_TOGGLE_EN
        tx_tog_nxt  = tx_tog;
        rx_tog_nxt  = rx_tog;
`endif
        case (state)
            IDLE: begin
                if (token_match && (in_pid == PID_IN)) begin
                    avail_nxt = 1'b1;
                    if (bus.tx_data_valid) begin
                        state_nxt   = TX_DATA;
                        pkt_out_nxt = {SYNC, tx_pid, bus.tx_data, 19'b0};
                    end else begin
                        state_nxt   = SEND_HS;
                        pkt_out_nxt = {SYNC, PID_NAK, 83'b0};
                    end
                end else if (token_match && (in_pid == PID_OUT)) begin
                    state_nxt = RX_WAIT;
                    timer_nxt = 8'd0;
                end
            end

            TX_DATA: begin
                if (bus.pkt_sent) begin
                    state_nxt = TX_HS;
                    avail_nxt = 1'b0;
                    timer_nxt = 8'd0;
                end
            end

            TX_HS: begin
                timer_nxt = timer + 8'd1;
                // A packet in the timeout cycle wins over the timeout
                if (bus.pkt_in_avail && !token_good) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    if (pkt_good && (in_pid == PID_ACK)) begin
                        ok_nxt    = 1'b1;
                        taken_nxt = 1'b1;
`ifdef USB_DEV_TOGGLE_EN
                        tx_tog_nxt = ~tx_tog;
`endif
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end

            RX_WAIT: begin
                timer_nxt = timer + 8'd1;
                if (bus.pkt_in_avail && !token_good) begin
                    state_nxt   = SEND_HS;
                    avail_nxt   = 1'b1;
                    pkt_out_nxt = {SYNC, PID_NAK, 83'b0};
                    if (data_good && !seq_ok) begin
                        // Retransmission of a payload already taken: re-ACK, drop data
                        pkt_out_nxt = {SYNC, PID_ACK, 83'b0};
                    end else if (data_good && bus.rx_ready) begin
                        pkt_out_nxt = {SYNC, PID_ACK, 83'b0};
                        rx_data_nxt = in_payload;
                        rxv_nxt     = 1'b1;
`ifdef USB_DEV_TOGGLE_EN
                        rx_tog_nxt  = ~rx_tog;
`endif
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end

            SEND_HS: begin
                if (bus.pkt_sent) begin
                    state_nxt = IDLE;
                    avail_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    ok_nxt    = (pkt_out_q[90:83] == PID_ACK);
                end
            end

            default: begin
                state_nxt = IDLE;
                avail_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            timer     <= 8'd0;
            pkt_out_q <= 99'b0;
            avail_q   <= 1'b0;
            taken_q   <= 1'b0;
            rx_data_q <= 64'b0;
            rxv_q     <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            pkt_out_q <= pkt_out_nxt;
            avail_q   <= avail_nxt;
            taken_q   <= taken_nxt;
            rx_data_q <= rx_data_nxt;
            rxv_q     <= rxv_nxt;
            done_q    <= done_nxt;
            ok_q      <= ok_nxt;
        end
    end

    assign bus.pkt_out       = pkt_out_q;
    assign bus.pkt_out_avail = avail_q;
    assign bus.tx_data_taken = taken_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_data_valid = rxv_q;
    assign bus.txn_done      = done_q;
    assign bus.txn_ok        = ok_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_dev_protocol.sv
// ============================================================================
// Module      : tb_usb_dev_protocol
// Description : Self-checking bench for usb_dev_protocol (vector table plus
//               pkt_out scoreboard). Honours USB_DEV_TOGGLE_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_usb_dev_protocol;

    localparam logic [7:0] TO_LEN    = 8'd20;
    localparam logic [3:0] EP        = 4'd4;
    localparam logic [7:0] SYNC      = 8'h01;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    localparam logic [1:0] R_NONE = 2'd0;
    localparam logic [1:0] R_DATA = 2'd1;
    localparam logic [1:0] R_ACK  = 2'd2;
    localparam logic [1:0] R_NAK  = 2'd3;

    typedef struct {
        string       name;
        logic [7:0]  tok_pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic        tok_corrupt;
        logic        tx_valid;
        logic [63:0] payload;
        logic [7:0]  reply_pid;
        logic        reply_corrupt;
        logic        rx_ready;
        logic [1:0]  exp_resp;
        logic        exp_done;
        logic        exp_ok;
        logic        exp_taken;
        logic        exp_rxv;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    usb_dev_protocol_if bus();

    usb_dev_protocol #(
        .TIMEOUT_LEN (TO_LEN),
        .ENDP        (EP)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [98:0] exp_q[$];
    logic [98:0] held      = '0;
    logic        prev_avail = 1'b0;
    int          done_cnt  = 0;
    int          taken_cnt = 0;
    int          rxv_cnt   = 0;
    logic        last_ok   = 1'b0;
    logic        tb_tx_tog = 1'b0;
    logic        tb_rx_tog = 1'b0;

    task automatic check_vec(input string name, input logic [98:0] act, input logic [98:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard on pkt_out, pulse counters
    always @(posedge clk) begin
        #1;
        if (bus.pkt_out_avail && !prev_avail) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt_out: got %h expected none", bus.pkt_out);
                held = bus.pkt_out;
            end else begin
                held = exp_q.pop_front();
                check_vec("pkt_out", bus.pkt_out, held);
            end
        end else if (bus.pkt_out_avail) begin
            check_vec("pkt_out_stable", bus.pkt_out, held);
        end
        prev_avail = bus.pkt_out_avail;
        if (bus.txn_done === 1'b1) begin
            done_cnt++;
            last_ok = bus.txn_ok;
        end
        if (bus.tx_data_taken === 1'b1) taken_cnt++;
        if (bus.rx_data_valid === 1'b1) rxv_cnt++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pkt(input logic [7:0] pid, input logic [82:0] body, input logic corrupt);
        @(negedge clk);
        bus.pkt_in         = {SYNC, pid, body};
        bus.pkt_in_avail   = 1'b1;
        bus.pkt_in_corrupt = corrupt;
        @(negedge clk);
        bus.pkt_in_avail   = 1'b0;
        bus.pkt_in_corrupt = 1'b0;
    endtask

    task automatic pulse_sent();
        @(negedge clk);
        bus.pkt_sent = 1'b1;
        @(negedge clk);
        bus.pkt_sent = 1'b0;
    endtask

    task automatic note_taken();
`ifdef USB_DEV_TOGGLE_EN
        tb_tx_tog = ~tb_tx_tog;
`endif
    endtask

    task automatic note_accepted();
`ifdef USB_DEV_TOGGLE_EN
        tb_rx_tog = ~tb_rx_tog;
`endif
    endtask

    function automatic logic [98:0] data_pkt(input logic [63:0] payload);
        return {SYNC, (tb_tx_tog ? PID_DATA1 : PID_DATA0), payload, 19'b0};
    endfunction

    function automatic vec_t mk(input string name, input logic [7:0] tok_pid, input logic [6:0] addr,
                                input logic [3:0] endp, input logic tok_corrupt, input logic tx_valid,
                                input logic [63:0] payload, input logic [7:0] reply_pid,
                                input logic reply_corrupt, input logic rx_ready, input logic [1:0] exp_resp,
                                input logic exp_done, input logic exp_ok, input logic exp_taken,
                                input logic exp_rxv);
        vec_t v;
        v.name = name;         v.tok_pid = tok_pid;     v.addr = addr;       v.endp = endp;
        v.tok_corrupt = tok_corrupt; v.tx_valid = tx_valid; v.payload = payload;
        v.reply_pid = reply_pid; v.reply_corrupt = reply_corrupt; v.rx_ready = rx_ready;
        v.exp_resp = exp_resp; v.exp_done = exp_done;   v.exp_ok = exp_ok;
        v.exp_taken = exp_taken; v.exp_rxv = exp_rxv;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int d0 = done_cnt;
        int t0 = taken_cnt;
        int r0 = rxv_cnt;
        bus.tx_data       = v.payload;
        bus.tx_data_valid = v.tx_valid;
        bus.rx_ready      = v.rx_ready;
        if (v.tok_pid == PID_IN) begin
            if (v.exp_resp == R_DATA) exp_q.push_back(data_pkt(v.payload));
            else if (v.exp_resp == R_NAK) exp_q.push_back({SYNC, PID_NAK, 83'b0});
        end
        drive_pkt(v.tok_pid, {v.addr, v.endp, 72'b0}, v.tok_corrupt);
        if (v.tok_pid == PID_IN) begin
            check_bit({v.name, "_avail_latency"}, bus.pkt_out_avail, v.exp_resp != R_NONE);
            if (v.exp_resp != R_NONE) begin
                wait_cycles(2);
                pulse_sent();
                if (v.exp_resp == R_DATA) begin
                    wait_cycles(2);
                    drive_pkt(v.reply_pid, 83'b0, v.reply_corrupt);
                end
            end
        end else begin
            check_bit({v.name, "_no_resp_to_out"}, bus.pkt_out_avail, 1'b0);
            if (v.exp_resp != R_NONE) begin
                exp_q.push_back({SYNC, (v.exp_resp == R_ACK) ? PID_ACK : PID_NAK, 83'b0});
                wait_cycles(1);
                drive_pkt(v.reply_pid, {v.payload, 19'b0}, v.reply_corrupt);
                check_bit({v.name, "_hs_latency"}, bus.pkt_out_avail, 1'b1);
                wait_cycles(1);
                pulse_sent();
            end
        end
        wait_cycles(3);
        check_int({v.name, "_done"}, done_cnt - d0, v.exp_done ? 1 : 0);
        if (v.exp_done) check_bit({v.name, "_ok"}, last_ok, v.exp_ok);
        check_int({v.name, "_taken"}, taken_cnt - t0, v.exp_taken ? 1 : 0);
        check_int({v.name, "_rx_valid"}, rxv_cnt - r0, v.exp_rxv ? 1 : 0);
        if (v.exp_rxv) check_vec({v.name, "_rx_data"}, {35'b0, bus.rx_data}, {35'b0, v.payload});
        if (v.exp_taken) note_taken();
        if (v.exp_rxv) note_accepted();
    endtask

    task automatic check_all_zero(input string name);
        check_vec({name, "_pkt_out"}, bus.pkt_out, 99'b0);
        check_bit({name, "_avail"}, bus.pkt_out_avail, 1'b0);
        check_bit({name, "_taken"}, bus.tx_data_taken, 1'b0);
        check_vec({name, "_rx_data"}, {35'b0, bus.rx_data}, 99'b0);
        check_bit({name, "_rx_valid"}, bus.rx_data_valid, 1'b0);
        check_bit({name, "_done"}, bus.txn_done, 1'b0);
        check_bit({name, "_ok"}, bus.txn_ok, 1'b0);
    endtask

    vec_t vecs[13];

    initial begin
        int d0;
        int t0;
        vecs[0]  = mk("in_ack",        PID_IN,  7'd5, 4'd4, 1'b0, 1'b1, 64'hDEADBEEF_01234567, PID_ACK,   1'b0, 1'b1, R_DATA, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[1]  = mk("in_nak",        PID_IN,  7'd5, 4'd4, 1'b0, 1'b0, 64'h0,                 PID_ACK,   1'b0, 1'b1, R_NAK,  1'b1, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk("out_ack",       PID_OUT, 7'd5, 4'd4, 1'b0, 1'b0, 64'h55AA,              PID_DATA0, 1'b0, 1'b1, R_ACK,  1'b1, 1'b1, 1'b0, 1'b1);
        vecs[3]  = mk("out_corrupt",   PID_OUT, 7'd5, 4'd4, 1'b0, 1'b0, 64'h1234,              PID_DATA0, 1'b1, 1'b1, R_NAK,  1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk("bad_addr",      PID_OUT, 7'd6, 4'd4, 1'b0, 1'b0, 64'h0,                 PID_DATA0, 1'b0, 1'b1, R_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk("in_host_nak",   PID_IN,  7'd5, 4'd4, 1'b0, 1'b1, 64'hCAFEF00D_00000001, PID_NAK,   1'b0, 1'b1, R_DATA, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk("out_data1",     PID_OUT, 7'd5, 4'd4, 1'b0, 1'b0, 64'hA5A5_0F0F_1111_2222, PID_DATA1, 1'b0, 1'b1, R_ACK, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[7]  = mk("out_not_ready", PID_OUT, 7'd5, 4'd4, 1'b0, 1'b0, 64'h7777,              PID_DATA0, 1'b0, 1'b0, R_NAK,  1'b1, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk("bad_endp",      PID_IN,  7'd5, 4'd3, 1'b0, 1'b1, 64'h1,                 PID_ACK,   1'b0, 1'b1, R_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk("out_ack_pid",   PID_OUT, 7'd5, 4'd4, 1'b0, 1'b0, 64'h0,                 PID_ACK,   1'b0, 1'b1, R_NAK,  1'b1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk("in_ack2",       PID_IN,  7'd5, 4'd4, 1'b0, 1'b1, 64'h0123456789ABCDEF, PID_ACK,   1'b0, 1'b1, R_DATA, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[11] = mk("in_bad_crc",    PID_IN,  7'd5, 4'd4, 1'b1, 1'b1, 64'h2,                 PID_ACK,   1'b0, 1'b1, R_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk("in_hs_corrupt", PID_IN,  7'd5, 4'd4, 1'b0, 1'b1, 64'hFFFF_0000_FFFF_0000, PID_ACK, 1'b1, 1'b1, R_DATA, 1'b1, 1'b0, 1'b0, 1'b0);

        bus.dev_addr       = 7'd5;
        bus.pkt_in         = '0;
        bus.pkt_in_avail   = 1'b0;
        bus.pkt_in_corrupt = 1'b0;
        bus.pkt_sent       = 1'b0;
        bus.tx_data        = '0;
        bus.tx_data_valid  = 1'b0;
        bus.rx_ready       = 1'b0;

        wait_cycles(3);
        check_all_zero("reset");
        rst_b = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // IN with no host handshake: abandon when timer reaches TO_LEN
        bus.tx_data = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.tx_data_valid = 1'b1;
        exp_q.push_back(data_pkt(bus.tx_data));
        drive_pkt(PID_IN, {7'd5, EP, 72'b0}, 1'b0);
        wait_cycles(1);
        pulse_sent();
        d0 = done_cnt;
        t0 = taken_cnt;
        wait_cycles(TO_LEN);
        check_int("tx_timeout_not_early", done_cnt - d0, 0);
        wait_cycles(1);
        check_int("tx_timeout_done", done_cnt - d0, 1);
        check_bit("tx_timeout_ok", last_ok, 1'b0);
        check_int("tx_timeout_taken", taken_cnt - t0, 0);

        // ACK landing in the timeout cycle is still accepted
        exp_q.push_back(data_pkt(bus.tx_data));
        drive_pkt(PID_IN, {7'd5, EP, 72'b0}, 1'b0);
        wait_cycles(1);
        pulse_sent();
        d0 = done_cnt;
        t0 = taken_cnt;
        wait_cycles(TO_LEN - 1);
        check_int("ack_at_timeout_idle_yet", done_cnt - d0, 0);
        drive_pkt(PID_ACK, 83'b0, 1'b0);
        check_int("ack_at_timeout_done", done_cnt - d0, 1);
        check_bit("ack_at_timeout_ok", last_ok, 1'b1);
        check_int("ack_at_timeout_taken", taken_cnt - t0, 1);
        note_taken();

        // OUT with no data packet
        bus.rx_ready = 1'b1;
        drive_pkt(PID_OUT, {7'd5, EP, 72'b0}, 1'b0);
        d0 = done_cnt;
        wait_cycles(TO_LEN);
        check_int("rx_timeout_not_early", done_cnt - d0, 0);
        wait_cycles(1);
        check_int("rx_timeout_done", done_cnt - d0, 1);
        check_bit("rx_timeout_ok", last_ok, 1'b0);

        // tx_data_valid dropping after capture must not disturb the packet
        bus.tx_data = 64'h1357_9BDF_2468_ACE0;
        bus.tx_data_valid = 1'b1;
        exp_q.push_back(data_pkt(bus.tx_data));
        drive_pkt(PID_IN, {7'd5, EP, 72'b0}, 1'b0);
        bus.tx_data_valid = 1'b0;
        bus.tx_data = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_cycles(3);
        pulse_sent();
        t0 = taken_cnt;
        wait_cycles(2);
        drive_pkt(PID_ACK, 83'b0, 1'b0);
        check_int("valid_drop_taken", taken_cnt - t0, 1);
        check_bit("valid_drop_ok", last_ok, 1'b1);
        note_taken();

        // Stray pkt_sent while idle
        d0 = done_cnt;
        pulse_sent();
        wait_cycles(3);
        check_int("idle_pkt_sent_done", done_cnt - d0, 0);
        check_bit("idle_pkt_sent_avail", bus.pkt_out_avail, 1'b0);

        // Reset while in TX_DATA
        bus.tx_data = 64'h0F0F_0F0F_0F0F_0F0F;
        bus.tx_data_valid = 1'b1;
        exp_q.push_back(data_pkt(bus.tx_data));
        drive_pkt(PID_IN, {7'd5, EP, 72'b0}, 1'b0);
        wait_cycles(1);
        d0 = done_cnt;
        rst_b = 1'b0;
        #1;
        check_all_zero("mid_reset");
        wait_cycles(2);
        rst_b = 1'b1;
        tb_tx_tog = 1'b0;
        tb_rx_tog = 1'b0;
        wait_cycles(2);
        check_int("mid_reset_no_done", done_cnt - d0, 0);
        run_vec(vecs[0]);

`ifdef USB_DEV_TOGGLE_EN
        // Duplicate DATA0 is ACKed but not delivered
        run_vec(mk("dup_first",  PID_OUT, 7'd5, 4'd4, 1'b0, 1'b0, 64'h1111, PID_DATA0, 1'b0, 1'b1, R_ACK, 1'b1, 1'b1, 1'b0, 1'b1));
        run_vec(mk("dup_second", PID_OUT, 7'd5, 4'd4, 1'b0, 1'b0, 64'h2222, PID_DATA0, 1'b0, 1'b1, R_ACK, 1'b1, 1'b1, 1'b0, 1'b0));
        check_vec("dup_rx_data_held", {35'b0, bus.rx_data}, {35'b0, 64'h1111});
        run_vec(mk("in_toggled", PID_IN, 7'd5, 4'd4, 1'b0, 1'b1, 64'hABCD, PID_ACK, 1'b0, 1'b1, R_DATA, 1'b1, 1'b1, 1'b1, 1'b0));
`endif

        wait_cycles(2);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
